nota_player: RTL and testbench

//  Melody transmitter; the source-side counterpart of the note-recognition FSM.
//  On request it plays the fixed 5-note sequence for a word class (adj/comp/adv).
//  It drives the same nota/ok/tom bus the recognizer consumes, so the pair loops back on-chip.
//  A 7-segment display shows the note currently on the bus.

---
 rtl/tp_pkg.sv | 73 +++++++
 rtl/nota_7seg.sv | 24 ++
 rtl/nota_player.sv | 119 +++++++++++
 tb/tb_nota_player.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_pkg.sv
// Shared codes for the note bus: note and word-class encodings, player states,
// the melody ROM and the active-low 7-segment glyphs.
package tp_pkg;

    typedef enum logic [2:0] {
        NOTA_ERRO = 3'd0,
        NOTA_DO   = 3'd1,
        NOTA_RE   = 3'd2,
        NOTA_MI   = 3'd3,
        NOTA_FA   = 3'd4,
        NOTA_SOL  = 3'd5,
        NOTA_LA   = 3'd6,
        NOTA_SI   = 3'd7
    } nota_t;

    typedef enum logic [1:0] {
        TIPO_INVALIDO = 2'd0,
        TIPO_ADJ      = 2'd1,
        TIPO_COMP     = 2'd2,
        TIPO_ADV      = 2'd3
    } tipo_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

    // Segment order {g,f,e,d,c,b,a}, a segment is lit when its bit is 0.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;

    function automatic nota_t pattern(input logic [1:0] tipo, input logic [2:0] idx);
        pattern = NOTA_ERRO;
        case (tipo)
            TIPO_ADJ: case (idx)
                3'd0: pattern = NOTA_DO;
                3'd1: pattern = NOTA_RE;
                3'd2: pattern = NOTA_MI;
                3'd3: pattern = NOTA_FA;
                3'd4: pattern = NOTA_SOL;
                default: pattern = NOTA_ERRO;
            endcase
            TIPO_COMP: case (idx)
                3'd0: pattern = NOTA_DO;
                3'd1: pattern = NOTA_MI;
                3'd2: pattern = NOTA_SOL;
                3'd3: pattern = NOTA_LA;
                3'd4: pattern = NOTA_SI;
                default: pattern = NOTA_ERRO;
            endcase
            TIPO_ADV: case (idx)
                3'd0: pattern = NOTA_DO;
                3'd1: pattern = NOTA_FA;
                3'd2: pattern = NOTA_RE;
                3'd3: pattern = NOTA_LA;
                3'd4: pattern = NOTA_MI;
                default: pattern = NOTA_ERRO;
            endcase
            default: pattern = NOTA_ERRO;
        endcase
    endfunction

endpackage

// File: rtl/nota_7seg.sv
// Combinational note-code to active-low 7-segment decoder (digits 0..7).
module nota_7seg
    import tp_pkg::*;
(
    input  logic [2:0] nota,
    output logic [6:0] display
);

    always_comb begin
        display = SEG_0;
        case (nota)
            3'd0: display = SEG_0;
            3'd1: display = SEG_1;
            3'd2: display = SEG_2;
            3'd3: display = SEG_3;
            3'd4: display = SEG_4;
            3'd5: display = SEG_5;
            3'd6: display = SEG_6;
            3'd7: display = SEG_7;
            default: display = SEG_0;
        endcase
    end

endmodule

// File: rtl/nota_player.sv
// Melody transmitter: plays the fixed 5-note pattern of a word class on the
// nota/ok/tom bus, one ok strobe per note followed by NOTE_GAP idle cycles.
module nota_player
    import tp_pkg::*;
#(
    parameter int NOTE_GAP = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] tipo_req,
    input  logic       tom_req,
    output logic       ok,
    output logic [2:0] nota,
    output logic       tom,
    output logic       busy,
    output logic       fim,
    output logic       erro,
    output logic [6:0] display
);

    // Gap counter loads NOTE_GAP-1 and counts down to 0, so it never wraps.
    localparam logic [3:0] GAP_LOAD = 4'(NOTE_GAP - 1);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [3:0] gap, gap_n;
    logic [1:0] tipo_q, tipo_n;
    logic       ok_n, tom_n, busy_n, fim_n, erro_n;
    logic [2:0] nota_n;
    logic [6:0] display_n;
    logic       last_note;

    assign last_note = (tipo_q == TIPO_INVALIDO) || (idx == LAST_IDX);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        gap_n   = gap;
        tipo_n  = tipo_q;
        tom_n   = tom;
        nota_n  = nota;
        ok_n    = 1'b0;
        busy_n  = busy;
        fim_n   = 1'b0;
        erro_n  = erro;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_SEND;
                    tipo_n  = tipo_req;
                    tom_n   = tom_req;
                    idx_n   = 3'd0;
                    ok_n    = 1'b1;
                    nota_n  = pattern(tipo_req, 3'd0);
                    busy_n  = 1'b1;
                    erro_n  = 1'b0;
                end
            end
            ST_SEND: begin
                state_n = ST_GAP;
                gap_n   = GAP_LOAD;
            end
            ST_GAP: begin
                if (gap != 4'd0) begin
                    gap_n = gap - 4'd1;
                end else if (last_note) begin
                    state_n = ST_DONE;
                    fim_n   = 1'b1;
                    busy_n  = 1'b0;
                    erro_n  = (tipo_q == TIPO_INVALIDO);
                end else begin
                    state_n = ST_SEND;
                    idx_n   = idx + 3'd1;
                    ok_n    = 1'b1;
                    nota_n  = pattern(tipo_q, idx + 3'd1);
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    nota_7seg u_seg (
        .nota    (nota_n),
        .display (display_n)
    );

    // Every output is a flop fed from the next-state logic, so the display
    // always shows the glyph of the note currently on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= 3'd0;
            gap     <= 4'd0;
            tipo_q  <= 2'd0;
            ok      <= 1'b0;
            nota    <= 3'd0;
            tom     <= 1'b0;
            busy    <= 1'b0;
            fim     <= 1'b0;
            erro    <= 1'b0;
            display <= SEG_0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gap     <= gap_n;
            tipo_q  <= tipo_n;
            ok      <= ok_n;
            nota    <= nota_n;
            tom     <= tom_n;
            busy    <= busy_n;
            fim     <= fim_n;
            erro    <= erro_n;
            display <= display_n;
        end
    end

endmodule

// File: tb/tb_nota_player.sv
// Scoreboard bench for nota_player: stimulus predicts bus events from the
// timing rules, a monitor pops and compares them and decodes each melody back.
module tb_nota_player;

    localparam int G = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] tipo_req;
    logic       tom_req;
    logic       ok;
    logic [2:0] nota;
    logic       tom;
    logic       busy;
    logic       fim;
    logic       erro;
    logic [6:0] display;

    nota_player #(.NOTE_GAP(G)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .tipo_req (tipo_req),
        .tom_req  (tom_req),
        .ok       (ok),
        .nota     (nota),
        .tom      (tom),
        .busy     (busy),
        .fim      (fim),
        .erro     (erro),
        .display  (display)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_fim;
        int nota;
        bit tom;
        bit first;
        bit erro;
        int tipo;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  ready_edge = 0;
    int  pat[4][5];
    logic [6:0] seg_tab[8];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        pat[0] = '{0, 0, 0, 0, 0};
        pat[1] = '{1, 2, 3, 4, 5};
        pat[2] = '{1, 3, 5, 6, 7};
        pat[3] = '{1, 4, 2, 6, 3};
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ok"}, int'(ok), 0);
        chk({tag, "_nota"}, int'(nota), 0);
        chk({tag, "_tom"}, int'(tom), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fim"}, int'(fim), 0);
        chk({tag, "_erro"}, int'(erro), 0);
        chk({tag, "_display"}, int'(display), int'(7'b1000000));
    endtask

    // Reference model: a start sampled at edge e0 yields notes at e0+i*(G+1)
    // and fim after the last gap; the player is deaf until fim+2.
    task automatic accept(input int e0, input int t, input bit m);
        int len;
        ev_t e;
        len = (t == 0) ? 1 : 5;
        for (int i = 0; i < len; i++) begin
            e = '{cyc: e0 + i * (G + 1), is_fim: 1'b0, nota: pat[t][i], tom: m,
                  first: (i == 0), erro: 1'b0, tipo: t};
            q.push_back(e);
        end
        e = '{cyc: e0 + len * (G + 1), is_fim: 1'b1, nota: 0, tom: m,
              first: 1'b0, erro: (t == 0), tipo: t};
        q.push_back(e);
        ready_edge = e0 + len * (G + 1) + 2;
    endtask

    task automatic step(input bit s, input int t, input bit m);
        @(negedge clk);
        start    = s;
        tipo_req = 2'(t);
        tom_req  = m;
        if (s && (cyc + 1) >= ready_edge) accept(cyc + 1, t, m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset;
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_reset");
        ready_edge = 0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic int decode(input int notes[$]);
        bit match;
        if (notes.size() == 1 && notes[0] == 0) return 0;
        if (notes.size() != 5) return -1;
        for (int t = 1; t < 4; t++) begin
            match = 1'b1;
            for (int i = 0; i < 5; i++) if (notes[i] != pat[t][i]) match = 1'b0;
            if (match) return t;
        end
        return -1;
    endfunction

    // Monitor
    int  last_nota = 0;
    bit  tom_exp = 1'b0;
    bit  busy_exp = 1'b0;
    bit  erro_exp = 1'b0;
    int  heard[$];
    ev_t me;

    always @(negedge clk) begin
        if (reset) begin
            chk_reset_vals("reset_hold");
            q.delete();
            heard.delete();
            last_nota = 0;
            tom_exp = 1'b0;
            busy_exp = 1'b0;
            erro_exp = 1'b0;
        end else begin
            if (ok || fim) begin
                if (q.size() == 0) begin
                    chk("unexpected_ok", int'(ok), 0);
                    chk("unexpected_fim", int'(fim), 0);
                end else begin
                    me = q.pop_front();
                    chk("event_time", cyc, me.cyc);
                    chk("event_kind_fim", int'(fim), int'(me.is_fim));
                    chk("event_kind_ok", int'(ok), int'(!me.is_fim));
                    if (!me.is_fim) begin
                        chk("nota", int'(nota), me.nota);
                        if (me.first) begin
                            busy_exp = 1'b1;
                            erro_exp = 1'b0;
                            heard.delete();
                        end
                        tom_exp = me.tom;
                        last_nota = me.nota;
                        heard.push_back(int'(nota));
                    end else begin
                        busy_exp = 1'b0;
                        erro_exp = me.erro;
                        chk("loopback_tipo", decode(heard), me.tipo);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("event_time", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            chk("busy", int'(busy), int'(busy_exp));
            chk("erro", int'(erro), int'(erro_exp));
            chk("nota_hold", int'(nota), last_nota);
            chk("tom", int'(tom), int'(tom_exp));
            chk("display", int'(display), int'(seg_tab[last_nota]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tipo_req = 2'd0;
        tom_req  = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        idle(20);
        chk_reset_vals("after_idle");

        // adj with tom=1
        step(1'b1, 1, 1'b1);
        idle(25);

        // comp then adv, start held through the sequences
        step(1'b1, 2, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 3, 1'b0);
        idle(25);

        // invalid class, then a valid start clears erro
        step(1'b1, 0, 1'b0);
        idle(8);
        step(1'b1, 1, 1'b0);
        idle(25);

        // start pulsed during a running sequence
        step(1'b1, 3, 1'b1);
        for (int i = 0; i < 24; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        idle(25);

        // reset during the third gap, no fim afterwards
        step(1'b1, 1, 1'b1);
        idle(9);
        do_reset();
        idle(25);
        step(1'b1, 2, 1'b1);
        idle(25);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 100 && q.size() > 0; i++) idle(1);
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
